// File: rtl/puf_pkg.sv
// Shared state encoding, chain drive levels and the challenge expander
// for the arbiter-PUF controller.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RELAX  = 3'd1,
    FIRE   = 3'd2,
    SAMPLE = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } puf_state_e;

  localparam logic [1:0] PUF_LAUNCH = 2'b11;
  localparam logic [1:0] PUF_RELAX  = 2'b00;

  // Widest chain the expander handles; callers zero-extend.
  localparam int PUF_MAX_STAGES = 256;

  typedef logic [PUF_MAX_STAGES-1:0] puf_vec_t;

  function automatic puf_vec_t puf_expand(
    input puf_vec_t c,
    input puf_vec_t mask
  );
    return {c[PUF_MAX_STAGES-2:0], ^(c & mask)};
  endfunction

endpackage

// File: rtl/arbiter_chain.sv
// Arbiter delay chain: challenge-steered crossbar stages feeding an
// SR-style arbiter latch. Kept standalone so placement can pin it.
module arbiter_chain #(
  parameter int STAGES = 64
) (
  input  logic [1:0]        switch_i,
  input  logic [STAGES-1:0] challenge_i,
  output logic              resp_o
);

  logic top_w;
  logic bot_w;

  always_comb begin
    top_w = switch_i[1];
    bot_w = switch_i[0];
    for (int i = 0; i < STAGES; i++) begin
      if (challenge_i[i]) begin
        {top_w, bot_w} = {bot_w, top_w};
      end
    end
  end

  // First edge to arrive wins; a tie or a relaxed chain holds the result.
  always_latch begin
    if (top_w ^ bot_w) begin
      resp_o = top_w;
    end
  end

endmodule

// File: rtl/arbiter_puf_ctrl.sv
// Arbiter-PUF evaluator: expands a seed, majority-votes each derived bit.
// Define PUF_STABILITY_EN to add the per-bit unstable_o flags.
module arbiter_puf_ctrl
  import puf_pkg::*;
#(
  parameter int STAGES        = 64,
  parameter int RESP_BITS     = 32,
  parameter int VOTES         = 5,
  parameter int RELAX_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter logic [STAGES-1:0] TAP_MASK =
    STAGES'(64'hD800_0000_0000_0000)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [STAGES-1:0]    challenge_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [RESP_BITS-1:0] resp_o,
  output logic                 busy_o
`ifdef PUF_STABILITY_EN
  ,
  output logic [RESP_BITS-1:0] unstable_o
`endif
);

  localparam int VW   = $clog2(VOTES + 1);
  localparam int BW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int CMAX = (RELAX_CYCLES > SETTLE_CYCLES) ?
                        RELAX_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [VW-1:0] VLAST = VW'(VOTES - 1);
  localparam logic [VW-1:0] VHALF = VW'(VOTES / 2);
  localparam logic [VW-1:0] VALL  = VW'(VOTES);
  localparam logic [BW-1:0] BLAST = BW'(RESP_BITS - 1);
  localparam logic [CW-1:0] RLAST = CW'(RELAX_CYCLES - 1);
  localparam logic [CW-1:0] SLAST = CW'(SETTLE_CYCLES - 1);

  if ((VOTES % 2) == 0 || VOTES < 1 || STAGES < 2 ||
      STAGES > PUF_MAX_STAGES || RESP_BITS < 1 ||
      RELAX_CYCLES < 1 || SETTLE_CYCLES < 3) begin : g_bad_cfg
    $error("arbiter_puf_ctrl: illegal parameter set");
  end

  puf_state_e state_q, state_d;
  logic [STAGES-1:0]    c_q, c_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [VW-1:0]        vote_q, vote_d;
  logic [VW-1:0]        ones_q, ones_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [1:0]           sync_q, sync_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
`ifdef PUF_STABILITY_EN
  logic [RESP_BITS-1:0] unst_q, unst_d;
`endif

  logic [1:0] chain_sw;
  logic       chain_resp;

  assign chain_sw = (state_q == FIRE) ? PUF_LAUNCH : PUF_RELAX;

  arbiter_chain #(
    .STAGES(STAGES)
  ) u_chain (
    .switch_i    (chain_sw),
    .challenge_i (c_q),
    .resp_o      (chain_resp)
  );

  // Free-running: the latch settles asynchronously to clk_i.
  assign sync_d = {sync_q[0], chain_resp};

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    bit_d   = bit_q;
    vote_d  = vote_q;
    ones_d  = ones_q;
    cyc_d   = cyc_q;
    resp_d  = resp_q;
`ifdef PUF_STABILITY_EN
    unst_d  = unst_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          c_d     = challenge_i;
          bit_d   = '0;
          vote_d  = '0;
          ones_d  = '0;
          cyc_d   = '0;
`ifdef PUF_STABILITY_EN
          unst_d  = '0;
`endif
          state_d = RELAX;
        end
      end
      RELAX: begin
        if (cyc_q == RLAST) begin
          cyc_d   = '0;
          state_d = FIRE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      FIRE: begin
        if (cyc_q == SLAST) begin
          cyc_d   = '0;
          state_d = SAMPLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      SAMPLE: begin
        ones_d = ones_q + VW'(sync_q[1]);
        if (vote_q == VLAST) begin
          state_d = NEXT;
        end else begin
          vote_d  = vote_q + 1'b1;
          state_d = RELAX;
        end
      end
      NEXT: begin
        resp_d[bit_q] = (ones_q > VHALF);
`ifdef PUF_STABILITY_EN
        unst_d[bit_q] = (ones_q != '0) && (ones_q != VALL);
`endif
        ones_d = '0;
        vote_d = '0;
        c_d    = STAGES'(puf_expand(puf_vec_t'(c_q),
                                    puf_vec_t'(TAP_MASK)));
        if (bit_q == BLAST) begin
          state_d = DONE;
        end else begin
          bit_d   = bit_q + 1'b1;
          state_d = RELAX;
        end
      end
      DONE: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      c_q     <= '0;
      bit_q   <= '0;
      vote_q  <= '0;
      ones_q  <= '0;
      cyc_q   <= '0;
      sync_q  <= '0;
      resp_q  <= '0;
`ifdef PUF_STABILITY_EN
      unst_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      bit_q   <= bit_d;
      vote_q  <= vote_d;
      ones_q  <= ones_d;
      cyc_q   <= cyc_d;
      sync_q  <= sync_d;
      resp_q  <= resp_d;
`ifdef PUF_STABILITY_EN
      unst_q  <= unst_d;
`endif
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign resp_o       = resp_q;
`ifdef PUF_STABILITY_EN
  assign unstable_o   = unst_q;
`endif

endmodule
